// File: rtl/histogram_stream.sv
// Streaming histogram: accumulates samples into saturating bin counters, then
// reads every bin out over a valid/ready handshake before accepting samples again.
module histogram_stream #(
  parameter int DATA_W        = 16,
  parameter int NUM_BINS      = 16,
  parameter int BIN_LSB       = 8,
  parameter int COUNT_W       = 8,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        start_readout,
  input  logic                        clear,
  output logic [COUNT_W-1:0]          out_count,
  output logic [$clog2(NUM_BINS)-1:0] out_bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        sat_flag
);

  localparam int BIN_W = $clog2(NUM_BINS);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  state_t             state_r;
  logic [COUNT_W-1:0] bins_r [NUM_BINS];
  logic               sat_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [BIN_W-1:0]   out_bin_r;

  logic [BIN_W-1:0]   sample_bin_s;
  logic               accept_s;
  logic               xfer_s;
  logic               last_xfer_s;
  logic [COUNT_W-1:0] inc_val_s;
  logic               inc_sat_s;

  // Returns {saturated, next_count}; a full counter stays put and reports saturation.
  function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] value);
    if (&value) begin
      return {1'b1, value};
    end else begin
      return {1'b0, value + COUNT_W'(1'b1)};
    end
  endfunction

  // Sample decode and handshake qualifiers.
  always_comb begin
    sample_bin_s           = sample_in[BIN_LSB +: BIN_W];
    accept_s               = (state_r == ST_ACCUM) && sample_valid;
    xfer_s                 = out_valid_r && out_ready;
    last_xfer_s            = xfer_s && out_last_r;
    {inc_sat_s, inc_val_s} = sat_inc(bins_r[sample_bin_s]);
  end

  // Bin counters: increments only in ACCUM, optional zeroing on transfer only in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BINS; i++) bins_r[i] <= {COUNT_W{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < NUM_BINS; i++) bins_r[i] <= {COUNT_W{1'b0}};
    end else begin
      if (accept_s) bins_r[sample_bin_s] <= inc_val_s;
      if ((CLEAR_ON_READ != 0) && xfer_s) bins_r[out_bin_r] <= {COUNT_W{1'b0}};
    end
  end

  // Sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if (clear) begin
      sat_r <= 1'b0;
    end else if (accept_s && inc_sat_s) begin
      sat_r <= 1'b1;
    end else if ((CLEAR_ON_READ != 0) && last_xfer_s) begin
      sat_r <= 1'b0;
    end
  end

  // Mode FSM; out_bin_r doubles as the read index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_ACCUM;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_bin_r   <= {BIN_W{1'b0}};
    end else if (clear) begin
      state_r     <= ST_ACCUM;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_bin_r   <= {BIN_W{1'b0}};
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (start_readout) begin
            state_r     <= ST_READ;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            out_bin_r   <= {BIN_W{1'b0}};
          end
        end
        ST_READ: begin
          if (xfer_s) begin
            if (out_last_r) begin
              state_r     <= ST_ACCUM;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_bin_r   <= {BIN_W{1'b0}};
            end else begin
              out_bin_r  <= out_bin_r + BIN_W'(1'b1);
              out_last_r <= (out_bin_r + BIN_W'(1'b1)) == BIN_W'(NUM_BINS - 1);
            end
          end
        end
        default: begin
          state_r     <= ST_ACCUM;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_bin_r   <= {BIN_W{1'b0}};
        end
      endcase
    end
  end

  assign sample_ready = (state_r == ST_ACCUM);
  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign out_bin      = out_bin_r;
  assign out_count    = out_valid_r ? bins_r[out_bin_r] : {COUNT_W{1'b0}};
  assign sat_flag     = sat_r;

endmodule
